ambilight_zone_writer: RTL and testbench
========================================

AMBILIGHT_ZONE_WRITER -- requirements
Module: ambilight_zone_writer

Interface
REQ-001 SHALL have parameter ZONE_W_LOG2, default 4, meaning log2 of zone width in pixels.
REQ-002 SHALL have parameter ZONE_H_LOG2, default 4, meaning log2 of zone height in lines.
REQ-003 SHALL have parameter ZONES_X, default 40, meaning zones per line, so active width = ZONES_X<<ZONE_W_LOG2.
REQ-004 SHALL have parameter ZONES_Y, default 30, meaning zone bands per frame.
REQ-005 SHALL have parameter BASE_ADDR, default 13'd0, meaning word address of zone 0.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port pix_valid, input, 1, pixel strobe.
REQ-009 SHALL have port pix_sof, input, 1, first pixel of frame, qualified by pix_valid.
REQ-010 SHALL have port pix_data, input, 24, pixel {R[23:16],G[15:8],B[7:0]}.
REQ-011 SHALL have port address2, output, 13, memory word address.
REQ-012 SHALL have ports chipselect2 and write2, output, 1 each, asserted together for one cycle per write.
REQ-013 SHALL have port writedata2, output, 32, write data.
REQ-014 SHALL have port byteenable2, output, 4, constant 4'hF.
REQ-015 SHALL have port clken2, output, 1, constant 1 out of reset.
REQ-016 SHALL have ports busy (drain active), overrun (sticky error) and frame_count[15:0] (completed frames), outputs.

Function
REQ-017 SHALL ignore all pixels until the first pix_valid&pix_sof after reset; that pixel is column 0, row 0.
REQ-018 SHALL advance column per valid pixel, wrap to 0 at width-1 and advance row; row wraps to 0 after ZONES_Y<<ZONE_H_LOG2 lines.
REQ-019 SHALL keep per-zone R, G, B accumulators of 8+ZONE_W_LOG2+ZONE_H_LOG2 bits each, ZONES_X sets, adding the pixel to zone col>>ZONE_W_LOG2.
REQ-020 SHALL, on the last pixel of a band's last line, snapshot each zone average (sum >> (ZONE_W_LOG2+ZONE_H_LOG2), truncated) into a ZONES_X x 24-bit drain buffer, including that pixel, and clear all accumulators in the same cycle.
REQ-021 SHALL start drain the cycle after snapshot: states IDLE -> DRAIN -> (STATUS if last band) -> IDLE.
REQ-022 SHALL in DRAIN issue one write per cycle, zones 0..ZONES_X-1 ascending, address2 = BASE_ADDR + band*ZONES_X + zone, writedata2 = {8'h00, avg}.
REQ-023 SHALL increment frame_count (wrapping at 16 bits) at the last band's snapshot and, in STATUS, write {16'h0000, frame_count} at BASE_ADDR + ZONES_X*ZONES_Y.
REQ-024 SHALL accept pixels during drain without stall; busy is high in DRAIN and STATUS.
REQ-025 SHALL, if a snapshot is due while busy, discard that band's results (accumulators still cleared), set overrun, and keep the current drain intact.
REQ-026 SHALL, on pix_sof mid-frame, clear accumulators and counters, treat the pixel as column 0 row 0, and not increment frame_count; an active drain completes.
REQ-027 SHALL hold chipselect2=write2=0 outside write cycles.

Reset
REQ-028 SHALL on reset: FSM IDLE, counters and accumulators 0, synced=0, address2=0, writedata2=0, chipselect2=write2=0, busy=0, overrun=0, frame_count=0, byteenable2=4'hF, clken2=1.
REQ-029 SHALL abort a drain immediately on reset with no further writes.

Verification (ZONE_W_LOG2=1, ZONE_H_LOG2=1, ZONES_X=2, ZONES_Y=2, BASE_ADDR=0; 4x4 frame)
REQ-030 SHALL cover: sof then 16 valid pixels of 0x102030 -> writes addr0,1 = 0x00102030 after line 2; addr2,3 = 0x00102030, then addr4 = 0x00000001; frame_count=1.
REQ-031 SHALL cover: zone 0 pixels 0x000000,0x000000,0x0000FF,0x0000FF -> addr0 = 0x0000007F (510>>2 truncated).
REQ-032 SHALL cover: pixels before first sof -> ignored, no writes.
REQ-033 SHALL cover: sof at pixel 6 of a frame -> no writes for aborted band, frame_count unchanged, next full frame writes correct values.
REQ-034 SHALL cover: band-2 completion while busy held by a prior drain (back-to-back pixels, ZONES_X forced larger than line gap) -> overrun=1, discarded band not written.
REQ-035 SHALL cover: reset asserted mid-DRAIN -> chipselect2=0 next cycle, all outputs at reset values.

Source files
------------

// File: rtl/ambilight_zone_writer.sv
// Ambilight zone averager: accumulates per-zone RGB sums over a pixel stream and
// writes each band's zone averages, plus a frame counter word, to a memory port.
module ambilight_zone_writer #(
  parameter int unsigned ZONE_W_LOG2 = 4,
  parameter int unsigned ZONE_H_LOG2 = 4,
  parameter int unsigned ZONES_X     = 40,
  parameter int unsigned ZONES_Y     = 30,
  parameter logic [12:0] BASE_ADDR   = 13'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_valid,
  input  logic        pix_sof,
  input  logic [23:0] pix_data,
  output logic [12:0] address2,
  output logic        chipselect2,
  output logic        write2,
  output logic [31:0] writedata2,
  output logic [3:0]  byteenable2,
  output logic        clken2,
  output logic        busy,
  output logic        overrun,
  output logic [15:0] frame_count
);

  localparam int unsigned WIDTH       = ZONES_X << ZONE_W_LOG2;
  localparam int unsigned HEIGHT      = ZONES_Y << ZONE_H_LOG2;
  localparam int unsigned COL_W       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned ROW_W       = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned ZIDX_W      = (ZONES_X > 1) ? $clog2(ZONES_X) : 1;
  localparam int unsigned BAND_W      = (ZONES_Y > 1) ? $clog2(ZONES_Y) : 1;
  localparam int unsigned SHIFT       = ZONE_W_LOG2 + ZONE_H_LOG2;
  localparam int unsigned ACC_W       = 8 + SHIFT;
  localparam int unsigned H_MASK      = (1 << ZONE_H_LOG2) - 1;
  localparam logic [12:0] STATUS_ADDR = 13'(BASE_ADDR + 13'(ZONES_X * ZONES_Y));

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_STATUS
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_synced;
  logic [COL_W-1:0]    r_col;
  logic [ROW_W-1:0]    r_row;
  logic [ACC_W-1:0]    r_acc_r [ZONES_X];
  logic [ACC_W-1:0]    r_acc_g [ZONES_X];
  logic [ACC_W-1:0]    r_acc_b [ZONES_X];
  logic [23:0]         r_buf   [ZONES_X];
  logic [ZIDX_W-1:0]   r_zone;
  logic                r_last_band;
  logic [15:0]         r_frame_count;
  logic                r_overrun;
  logic                r_wr;
  logic [12:0]         r_address;
  logic [31:0]         r_writedata;
  logic                r_busy;

  logic                w_take;
  logic [COL_W-1:0]    w_col;
  logic [ROW_W-1:0]    w_row;
  logic [ZIDX_W-1:0]   w_zone_hit;
  logic [ZIDX_W-1:0]   w_zone_inc;
  logic [BAND_W-1:0]   w_band_idx;
  logic                w_line_end;
  logic                w_last_row;
  logic                w_band_end;
  logic                w_frame_end;
  logic                w_accept;
  logic [ACC_W-1:0]    w_sum_r [ZONES_X];
  logic [ACC_W-1:0]    w_sum_g [ZONES_X];
  logic [ACC_W-1:0]    w_sum_b [ZONES_X];
  logic [23:0]         w_avg   [ZONES_X];
  logic [ZIDX_W-1:0]   w_zone_nxt;
  logic                w_wr_nxt;
  logic [12:0]         w_addr_nxt;
  logic [31:0]         w_data_nxt;

  // A start-of-frame pixel restarts geometry at (0,0) even mid-frame.
  assign w_take      = pix_valid && (pix_sof || r_synced);
  assign w_col       = pix_sof ? '0 : r_col;
  assign w_row       = pix_sof ? '0 : r_row;
  assign w_zone_hit  = ZIDX_W'(w_col >> ZONE_W_LOG2);
  assign w_band_idx  = BAND_W'(w_row >> ZONE_H_LOG2);
  assign w_line_end  = (w_col == COL_W'(WIDTH - 1));
  assign w_last_row  = (w_row == ROW_W'(HEIGHT - 1));
  assign w_band_end  = w_take && w_line_end && ((w_row & ROW_W'(H_MASK)) == ROW_W'(H_MASK));
  assign w_frame_end = w_band_end && w_last_row;
  assign w_accept    = w_band_end && (r_state == S_IDLE);
  assign w_zone_inc  = r_zone + ZIDX_W'(1);

  // Running sums including the current pixel; averages feed the snapshot.
  always_comb begin
    for (int unsigned z = 0; z < ZONES_X; z++) begin
      w_sum_r[z] = pix_sof ? '0 : r_acc_r[z];
      w_sum_g[z] = pix_sof ? '0 : r_acc_g[z];
      w_sum_b[z] = pix_sof ? '0 : r_acc_b[z];
      if (ZIDX_W'(z) == w_zone_hit) begin
        w_sum_r[z] = w_sum_r[z] + ACC_W'(pix_data[23:16]);
        w_sum_g[z] = w_sum_g[z] + ACC_W'(pix_data[15:8]);
        w_sum_b[z] = w_sum_b[z] + ACC_W'(pix_data[7:0]);
      end
      w_avg[z] = {8'(w_sum_r[z] >> SHIFT), 8'(w_sum_g[z] >> SHIFT), 8'(w_sum_b[z] >> SHIFT)};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_synced      <= 1'b0;
      r_col         <= '0;
      r_row         <= '0;
      r_last_band   <= 1'b0;
      r_frame_count <= 16'd0;
      r_overrun     <= 1'b0;
      for (int unsigned z = 0; z < ZONES_X; z++) begin
        r_acc_r[z] <= '0;
        r_acc_g[z] <= '0;
        r_acc_b[z] <= '0;
        r_buf[z]   <= 24'd0;
      end
    end else if (w_take) begin
      r_synced <= 1'b1;
      if (w_line_end) begin
        r_col <= '0;
        r_row <= w_last_row ? '0 : w_row + ROW_W'(1);
      end else begin
        r_col <= w_col + COL_W'(1);
        r_row <= w_row;
      end
      for (int unsigned z = 0; z < ZONES_X; z++) begin
        r_acc_r[z] <= w_band_end ? '0 : w_sum_r[z];
        r_acc_g[z] <= w_band_end ? '0 : w_sum_g[z];
        r_acc_b[z] <= w_band_end ? '0 : w_sum_b[z];
        if (w_accept) begin
          r_buf[z] <= w_avg[z];
        end
      end
      if (w_accept) begin
        r_last_band <= w_last_row;
      end
      // A band finishing while the previous drain is still running is dropped.
      if (w_band_end && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end
      if (w_frame_end) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_zone      <= '0;
      r_wr        <= 1'b0;
      r_address   <= 13'd0;
      r_writedata <= 32'd0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_zone      <= w_zone_nxt;
      r_wr        <= w_wr_nxt;
      r_address   <= w_addr_nxt;
      r_writedata <= w_data_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  // Write registers are loaded with the state they accompany, so each DRAIN/STATUS cycle is one write.
  always_comb begin
    w_state_nxt = r_state;
    w_zone_nxt  = r_zone;
    w_wr_nxt    = 1'b0;
    w_addr_nxt  = r_address;
    w_data_nxt  = r_writedata;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_DRAIN;
          w_zone_nxt  = '0;
          w_wr_nxt    = 1'b1;
          w_addr_nxt  = 13'(BASE_ADDR + 13'(w_band_idx) * 13'(ZONES_X));
          w_data_nxt  = {8'h00, w_avg[0]};
        end
      end
      S_DRAIN: begin
        if (r_zone == ZIDX_W'(ZONES_X - 1)) begin
          if (r_last_band) begin
            w_state_nxt = S_STATUS;
            w_wr_nxt    = 1'b1;
            w_addr_nxt  = STATUS_ADDR;
            w_data_nxt  = {16'h0000, r_frame_count};
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_zone_nxt = w_zone_inc;
          w_wr_nxt   = 1'b1;
          w_addr_nxt = r_address + 13'd1;
          w_data_nxt = {8'h00, r_buf[w_zone_inc]};
        end
      end
      S_STATUS: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign address2    = r_address;
  assign chipselect2 = r_wr;
  assign write2      = r_wr;
  assign writedata2  = r_writedata;
  assign byteenable2 = 4'hF;
  assign clken2      = 1'b1;
  assign busy        = r_busy;
  assign overrun     = r_overrun;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_ambilight_zone_writer.sv
// Directed bench: dut1 uses a 4x4 frame of 2x2 zones, dut2 a 4x2 frame of 1x1
// zones so that a band ends while the previous drain is still writing.
module tb_ambilight_zone_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid1, valid2, pix_sof;
  logic [23:0] pix_data;

  logic [12:0] addr1, addr2;
  logic        cs1, wr1, cs2, wr2;
  logic [31:0] data1, data2;
  logic [3:0]  be1, be2;
  logic        ck1, ck2, busy1, busy2, ovr1, ovr2;
  logic [15:0] fc1, fc2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [12:0] qa1[$], qa2[$];
  logic [31:0] qd1[$], qd2[$];
  logic [12:0] ea[5];
  logic [31:0] ed[5];
  logic [23:0] pat[16];

  always #5 clk = ~clk;

  ambilight_zone_writer #(
    .ZONE_W_LOG2(1), .ZONE_H_LOG2(1), .ZONES_X(2), .ZONES_Y(2), .BASE_ADDR(13'd0)
  ) dut1 (
    .clk(clk), .reset(reset), .pix_valid(valid1), .pix_sof(pix_sof), .pix_data(pix_data),
    .address2(addr1), .chipselect2(cs1), .write2(wr1), .writedata2(data1),
    .byteenable2(be1), .clken2(ck1), .busy(busy1), .overrun(ovr1), .frame_count(fc1)
  );

  ambilight_zone_writer #(
    .ZONE_W_LOG2(0), .ZONE_H_LOG2(0), .ZONES_X(4), .ZONES_Y(2), .BASE_ADDR(13'd0)
  ) dut2 (
    .clk(clk), .reset(reset), .pix_valid(valid2), .pix_sof(pix_sof), .pix_data(pix_data),
    .address2(addr2), .chipselect2(cs2), .write2(wr2), .writedata2(data2),
    .byteenable2(be2), .clken2(ck2), .busy(busy2), .overrun(ovr2), .frame_count(fc2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Write logger; chipselect2 and write2 must always move together.
  always @(negedge clk) begin
    if (cs1 || wr1) begin
      check_eq("cs_wr_pair1", 32'(wr1), 32'(cs1));
      if (cs1 && wr1) begin
        qa1.push_back(addr1);
        qd1.push_back(data1);
      end
    end
    if (cs2 || wr2) begin
      check_eq("cs_wr_pair2", 32'(wr2), 32'(cs2));
      if (cs2 && wr2) begin
        qa2.push_back(addr2);
        qd2.push_back(data2);
      end
    end
  end

  task automatic pix(input int unsigned which, input logic sof_i, input logic [23:0] d);
    @(negedge clk);
    pix_sof  = sof_i;
    pix_data = d;
    valid1   = (which == 1);
    valid2   = (which == 2);
  endtask

  task automatic stop_pix();
    @(negedge clk);
    valid1  = 1'b0;
    valid2  = 1'b0;
    pix_sof = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic verify(input string tag, input logic [12:0] qa[$], input logic [31:0] qd[$],
                        input int n);
    check_eq($sformatf("%s_count", tag), 32'(qa.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < qa.size()) begin
        check_eq($sformatf("%s_addr%0d", tag, i), 32'(qa[i]), 32'(ea[i]));
        check_eq($sformatf("%s_data%0d", tag, i), qd[i], ed[i]);
      end else begin
        check_eq($sformatf("%s_missing%0d", tag, i), 32'hFFFF_FFFF, ed[i]);
      end
    end
  endtask

  initial begin
    reset = 1'b1; valid1 = 1'b0; valid2 = 1'b0; pix_sof = 1'b0; pix_data = 24'd0;
    idle(3);
    check_eq("rst_cs", 32'(cs1), 32'd0);
    check_eq("rst_wr", 32'(wr1), 32'd0);
    check_eq("rst_addr", 32'(addr1), 32'd0);
    check_eq("rst_data", data1, 32'd0);
    check_eq("rst_be", 32'(be1), 32'hF);
    check_eq("rst_clken", 32'(ck1), 32'd1);
    check_eq("rst_busy", 32'(busy1), 32'd0);
    check_eq("rst_ovr", 32'(ovr1), 32'd0);
    check_eq("rst_fc", 32'(fc1), 32'd0);
    reset = 1'b0;

    // Pixels before any start-of-frame are ignored.
    for (int i = 0; i < 5; i++) pix(1, 1'b0, 24'hABCDEF);
    stop_pix();
    idle(10);
    check_eq("presync_writes", 32'(qa1.size()), 32'd0);
    check_eq("presync_fc", 32'(fc1), 32'd0);

    // Uniform frame, band 0 is written after line 2.
    pix(1, 1'b1, 24'h102030);
    for (int i = 1; i < 8; i++) pix(1, 1'b0, 24'h102030);
    stop_pix();
    idle(4);
    ea[0] = 13'd0; ed[0] = 32'h0010_2030;
    ea[1] = 13'd1; ed[1] = 32'h0010_2030;
    verify("uni_band0", qa1, qd1, 2);
    for (int i = 8; i < 16; i++) pix(1, 1'b0, 24'h102030);
    stop_pix();
    idle(6);
    ea[2] = 13'd2; ed[2] = 32'h0010_2030;
    ea[3] = 13'd3; ed[3] = 32'h0010_2030;
    ea[4] = 13'd4; ed[4] = 32'h0000_0001;
    verify("uni_frame", qa1, qd1, 5);
    check_eq("uni_fc", 32'(fc1), 32'd1);
    check_eq("uni_busy", 32'(busy1), 32'd0);

    // Per-zone averages with truncation.
    qa1.delete(); qd1.delete();
    pat = '{24'h000000, 24'h000000, 24'h102030, 24'h102030,
            24'h0000FF, 24'h0000FF, 24'h102030, 24'h102030,
            24'hFF0000, 24'h00FF00, 24'h808080, 24'h808080,
            24'h0000FF, 24'h030303, 24'h808080, 24'h808080};
    for (int i = 0; i < 16; i++) pix(1, (i == 0), pat[i]);
    stop_pix();
    idle(6);
    ea[0] = 13'd0; ed[0] = 32'h0000_007F;
    ea[1] = 13'd1; ed[1] = 32'h0010_2030;
    ea[2] = 13'd2; ed[2] = 32'h0040_4040;
    ea[3] = 13'd3; ed[3] = 32'h0080_8080;
    ea[4] = 13'd4; ed[4] = 32'h0000_0002;
    verify("avg", qa1, qd1, 5);
    check_eq("avg_fc", 32'(fc1), 32'd2);

    // Start-of-frame arriving at pixel 6 aborts the partial band.
    qa1.delete(); qd1.delete();
    pix(1, 1'b1, 24'hFFFFFF);
    for (int i = 1; i < 6; i++) pix(1, 1'b0, 24'hFFFFFF);
    stop_pix();
    idle(4);
    check_eq("abort_writes", 32'(qa1.size()), 32'd0);
    check_eq("abort_fc", 32'(fc1), 32'd2);
    pix(1, 1'b1, 24'h445566);
    for (int i = 1; i < 16; i++) pix(1, 1'b0, 24'h445566);
    stop_pix();
    idle(6);
    for (int i = 0; i < 4; i++) begin
      ea[i] = 13'(i); ed[i] = 32'h0044_5566;
    end
    ea[4] = 13'd4; ed[4] = 32'h0000_0003;
    verify("resync", qa1, qd1, 5);
    check_eq("resync_fc", 32'(fc1), 32'd3);

    // dut2: second band completes while band 0 is still draining.
    for (int i = 0; i < 4; i++) pix(2, (i == 0), 24'(i + 1));
    for (int i = 0; i < 4; i++) pix(2, 1'b0, 24'h0000AA);
    stop_pix();
    idle(8);
    for (int i = 0; i < 4; i++) begin
      ea[i] = 13'(i); ed[i] = 32'(i + 1);
    end
    verify("ovr", qa2, qd2, 4);
    check_eq("ovr_flag", 32'(ovr2), 32'd1);
    check_eq("ovr_fc", 32'(fc2), 32'd1);
    check_eq("ovr_busy", 32'(busy2), 32'd0);
    check_eq("ovr_dut1_clear", 32'(ovr1), 32'd0);

    // Reset in the middle of a drain.
    qa1.delete(); qd1.delete();
    pix(1, 1'b1, 24'h0A0B0C);
    for (int i = 1; i < 8; i++) pix(1, 1'b0, 24'h0A0B0C);
    stop_pix();
    check_eq("mid_drain_cs", 32'(cs1), 32'd1);
    check_eq("mid_drain_busy", 32'(busy1), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("abort_rst_cs", 32'(cs1), 32'd0);
    check_eq("abort_rst_wr", 32'(wr1), 32'd0);
    check_eq("abort_rst_busy", 32'(busy1), 32'd0);
    check_eq("abort_rst_data", data1, 32'd0);
    check_eq("abort_rst_addr", 32'(addr1), 32'd0);
    check_eq("abort_rst_fc", 32'(fc1), 32'd0);
    check_eq("abort_rst_ovr2", 32'(ovr2), 32'd0);
    check_eq("abort_rst_fc2", 32'(fc2), 32'd0);
    check_eq("abort_rst_be", 32'(be1), 32'hF);
    check_eq("abort_rst_clken", 32'(ck1), 32'd1);
    reset = 1'b0;
    qa1.delete(); qd1.delete();
    idle(6);
    check_eq("post_rst_writes", 32'(qa1.size()), 32'd0);
    check_eq("post_rst_busy", 32'(busy1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
